// File: rtl/esp_link_tx.sv
// esp_link_tx: byte-wide FIFO feeding an asynchronous serial framer on the FPGA->ESP line.
// Frame = start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
// Port and parameter names match the top_level integration and the esp_sig receive path.
module esp_link_tx #(
    parameter int unsigned CLKS_PER_BIT = 1736,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       sysclk_200mhz,
    input  logic       sys_rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       esp_tx
);

    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    localparam logic [BW-1:0] BaudLast   = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BaudPenult = BW'(CLKS_PER_BIT - 2);
    localparam logic [CW-1:0] CountFull  = CW'(FIFO_DEPTH);
    localparam logic          StopLast   = 1'(STOP_BITS - 1);
    localparam logic          OddParity  = (PARITY == 2);
    localparam logic          HasParity  = (PARITY != 0);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    // FIFO storage and bookkeeping
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] count_q;
    logic          rdy_en_q;

    // Framer state
    state_e        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic          stop_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic          esp_tx_q;
    logic          done_q;

    logic          push;
    logic          pop;
    logic          bit_end;
    logic          stop_end;
    logic          fifo_nonempty;
    logic [7:0]    head;

    // Handshake, pop decision and status derived from registered state only
    always_comb begin
        fifo_nonempty = (count_q != '0);
        bit_end       = (baud_q == BaudLast);
        stop_end      = (state_q == StStop) && bit_end && (stop_q == StopLast);
        pop           = fifo_nonempty && ((state_q == StIdle) || stop_end);
        // rdy_en_q holds tx_ready low through reset and for the reset edge itself
        tx_ready      = rdy_en_q && (count_q != CountFull);
        push          = tx_valid && tx_ready;
        head          = mem_q[rd_q];
        tx_busy       = (state_q != StIdle) || fifo_nonempty;
        tx_done       = done_q;
        esp_tx        = esp_tx_q;
    end

    // FIFO pointers, occupancy count and storage writes
    always_ff @(posedge sysclk_200mhz) begin
        if (!sys_rst_n) begin
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (push) begin
                mem_q[wr_q] <= tx_data;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Frame sequencer; esp_tx and tx_done are registered so the line never glitches
    always_ff @(posedge sysclk_200mhz) begin
        if (!sys_rst_n) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            esp_tx_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    esp_tx_q <= 1'b1;
                    if (pop) begin
                        shift_q  <= head;
                        par_q    <= (^head) ^ OddParity;
                        bit_q    <= '0;
                        baud_q   <= '0;
                        esp_tx_q <= 1'b0;
                        state_q  <= StStart;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        baud_q   <= '0;
                        esp_tx_q <= shift_q[0];
                        state_q  <= StData;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            if (HasParity) begin
                                esp_tx_q <= par_q;
                                state_q  <= StParity;
                            end else begin
                                esp_tx_q <= 1'b1;
                                stop_q   <= 1'b0;
                                state_q  <= StStop;
                            end
                        end else begin
                            bit_q    <= bit_q + 1'b1;
                            shift_q  <= shift_q >> 1;
                            esp_tx_q <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        baud_q   <= '0;
                        esp_tx_q <= 1'b1;
                        stop_q   <= 1'b0;
                        state_q  <= StStop;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (stop_q == StopLast) begin
                            if (pop) begin
                                // Chain straight into the next start bit, no idle cycle
                                shift_q  <= head;
                                par_q    <= (^head) ^ OddParity;
                                bit_q    <= '0;
                                esp_tx_q <= 1'b0;
                                state_q  <= StStart;
                            end else begin
                                esp_tx_q <= 1'b1;
                                state_q  <= StIdle;
                            end
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                        // Set one edge early so the pulse lands on the final stop cycle
                        if ((baud_q == BaudPenult) && (stop_q == StopLast)) begin
                            done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    esp_tx_q <= 1'b1;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_esp_link_tx.sv
// tb_esp_link_tx: directed, table-driven bench for esp_link_tx.
// Four instances cover the parameter sets: A (no parity, 1 stop), B (even, 2 stops),
// C (odd, 2 stops), all at 4 clocks/bit, and D at the default 1736 clocks/bit.
module tb_esp_link_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       a_valid, b_valid, c_valid, d_valid;
    logic       a_ready, b_ready, c_ready, d_ready;
    logic       a_busy, b_busy, c_busy, d_busy;
    logic       a_done, b_done, c_done, d_done;
    logic       a_tx, b_tx, c_tx, d_tx;

    int n_checks = 0;
    int n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    esp_link_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .sysclk_200mhz(clk), .sys_rst_n(rst_n), .tx_data(tx_data), .tx_valid(a_valid),
        .tx_ready(a_ready), .tx_busy(a_busy), .tx_done(a_done), .esp_tx(a_tx)
    );
    esp_link_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
        .sysclk_200mhz(clk), .sys_rst_n(rst_n), .tx_data(tx_data), .tx_valid(b_valid),
        .tx_ready(b_ready), .tx_busy(b_busy), .tx_done(b_done), .esp_tx(b_tx)
    );
    esp_link_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
        .sysclk_200mhz(clk), .sys_rst_n(rst_n), .tx_data(tx_data), .tx_valid(c_valid),
        .tx_ready(c_ready), .tx_busy(c_busy), .tx_done(c_done), .esp_tx(c_tx)
    );
    esp_link_tx #(.CLKS_PER_BIT(1736), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_d (
        .sysclk_200mhz(clk), .sys_rst_n(rst_n), .tx_data(tx_data), .tx_valid(d_valid),
        .tx_ready(d_ready), .tx_busy(d_busy), .tx_done(d_done), .esp_tx(d_tx)
    );

    // frame holds the transmitted bits in line order, bit 0 = start bit
    typedef struct {
        int          sel;
        logic [7:0]  data;
        logic [11:0] frame;
        int          nbits;
        int          cpb;
    } vec_t;

    vec_t vecs[6];

    function automatic logic get_tx(input int sel);
        case (sel)
            0: return a_tx;
            1: return b_tx;
            2: return c_tx;
            default: return d_tx;
        endcase
    endfunction

    function automatic logic get_ready(input int sel);
        case (sel)
            0: return a_ready;
            1: return b_ready;
            2: return c_ready;
            default: return d_ready;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0: return a_busy;
            1: return b_busy;
            2: return c_busy;
            default: return d_busy;
        endcase
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            0: return a_done;
            1: return b_done;
            2: return c_done;
            default: return d_done;
        endcase
    endfunction

    task automatic set_valid(input int sel, input logic v);
        case (sel)
            0: a_valid = v;
            1: b_valid = v;
            2: c_valid = v;
            default: d_valid = v;
        endcase
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge
    task automatic push_byte(input int sel, input logic [7:0] d);
        int waitc = 0;
        tx_data = d;
        set_valid(sel, 1'b1);
        while (!get_ready(sel) && waitc < 20000) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 20000) begin
            check_int("push_timeout", waitc, 0);
            set_valid(sel, 1'b0);
        end else begin
            @(posedge clk);
            @(negedge clk);
            set_valid(sel, 1'b0);
        end
    endtask

    // Push one byte into an idle instance and check every cycle of the resulting frame
    task automatic run_vec(input vec_t v, input string tag);
        int total    = v.nbits * v.cpb;
        int bit_err  = 0;
        int done_err = 0;
        int busy_err = 0;
        logic [11:0] f = v.frame;
        check_bit({tag, "_ready_pre"}, get_ready(v.sel), 1'b1);
        check_bit({tag, "_busy_pre"}, get_busy(v.sel), 1'b0);
        push_byte(v.sel, v.data);
        check_bit({tag, "_line_before_pop"}, get_tx(v.sel), 1'b1);
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            if (get_tx(v.sel) !== f[(k - 1) / v.cpb]) bit_err++;
            if (get_done(v.sel) !== (k == total)) done_err++;
            if (get_busy(v.sel) !== 1'b1) busy_err++;
        end
        check_int({tag, "_bit_errors"}, bit_err, 0);
        check_int({tag, "_done_errors"}, done_err, 0);
        check_int({tag, "_busy_errors"}, busy_err, 0);
        @(negedge clk);
        check_bit({tag, "_line_after"}, get_tx(v.sel), 1'b1);
        check_bit({tag, "_done_after"}, get_done(v.sel), 1'b0);
        check_bit({tag, "_busy_after"}, get_busy(v.sel), 1'b0);
    endtask

    // Passive receiver on instance A (4 clocks/bit, 10-bit frames)
    logic        mon_en = 1'b0;
    logic        mon_act = 1'b0;
    int          mon_cyc = 0;
    int          mon_idle = 0;
    int          mon_frames = 0;
    int          mon_done_cnt = 0;
    int          mon_done_bad = 0;
    int          mon_frame_bad = 0;
    logic [9:0]  mon_sh;
    logic [7:0]  mon_q[$];
    int          mon_gaps[$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (!mon_act) begin
                if (a_tx == 1'b0) begin
                    mon_act = 1'b1;
                    mon_cyc = 1;
                    if (mon_frames > 0) mon_gaps.push_back(mon_idle);
                end else begin
                    mon_idle++;
                end
            end else begin
                mon_cyc++;
            end
            if (mon_act && (mon_cyc % 4) == 2) mon_sh[(mon_cyc - 2) / 4] = a_tx;
            if (a_done) begin
                mon_done_cnt++;
                if (!(mon_act && mon_cyc == 40)) mon_done_bad++;
            end
            if (mon_act && mon_cyc == 40) begin
                if (mon_sh[0] !== 1'b0 || mon_sh[9] !== 1'b1) mon_frame_bad++;
                mon_q.push_back(mon_sh[8:1]);
                mon_frames++;
                mon_act  = 1'b0;
                mon_idle = 0;
            end
        end
    end

    task automatic mon_restart();
        @(posedge clk);
        mon_en        = 1'b0;
        mon_act       = 1'b0;
        mon_cyc       = 0;
        mon_idle      = 0;
        mon_frames    = 0;
        mon_done_cnt  = 0;
        mon_done_bad  = 0;
        mon_frame_bad = 0;
        mon_q.delete();
        mon_gaps.delete();
        mon_en        = 1'b1;
        @(negedge clk);
    endtask

    task automatic mon_wait(input int nframes, input int budget);
        int g = 0;
        while (mon_frames < nframes && g < budget) begin
            @(posedge clk);
            g++;
        end
        check_int("mon_frame_count", mon_frames, nframes);
    endtask

    task automatic mon_check_seq(input string tag, input logic [7:0] first, input int n);
        int gsum = 0;
        for (int i = 0; i < n; i++) begin
            if (i < mon_q.size()) check_int($sformatf("%s_byte%0d", tag, i), int'(mon_q[i]),
                                            int'(first) + i);
            else check_int($sformatf("%s_byte%0d_missing", tag, i), 0, 1);
        end
        foreach (mon_gaps[i]) gsum += mon_gaps[i];
        check_int({tag, "_gap_count"}, mon_gaps.size(), n - 1);
        check_int({tag, "_gap_cycles"}, gsum, 0);
        check_int({tag, "_done_pulses"}, mon_done_cnt, n);
        check_int({tag, "_done_misplaced"}, mon_done_bad, 0);
        check_int({tag, "_framing_errors"}, mon_frame_bad, 0);
    endtask

    initial begin
        vec_t v3c;
        int   sent, guard, bad_done, bad_line;
        logic low_seen, recovered;

        //                sel  data    frame     nbits cpb
        vecs[0] = '{0, 8'hA5, 12'h34A, 10, 4};     // 0,1,0,1,0,0,1,0,1,1
        vecs[1] = '{1, 8'h07, 12'hE0E, 12, 4};     // even parity 1, two stops
        vecs[2] = '{2, 8'h07, 12'hC0E, 12, 4};     // odd parity 0
        vecs[3] = '{1, 8'hFF, 12'hDFE, 12, 4};     // even parity 0
        vecs[4] = '{2, 8'h00, 12'hE00, 12, 4};     // odd parity 1
        vecs[5] = '{3, 8'hA5, 12'h34A, 10, 1736};  // default rate, 17360-cycle frame
        v3c     = '{0, 8'h3C, 12'h278, 10, 4};

        rst_n   = 1'b0;
        tx_data = 8'h00;
        a_valid = 1'b0;
        b_valid = 1'b0;
        c_valid = 1'b0;
        d_valid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_bit("rst_tx", a_tx, 1'b1);
        check_bit("rst_ready", a_ready, 1'b0);
        check_bit("rst_busy", a_busy, 1'b0);
        check_bit("rst_done", a_done, 1'b0);
        check_bit("rst_tx_d", d_tx, 1'b1);
        rst_n = 1'b1;
        check_bit("ready_before_first_edge", a_ready, 1'b0);
        @(negedge clk);
        check_bit("ready_after_first_edge", a_ready, 1'b1);

        // Single frames across parity/stop configurations and the default rate
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Burst with backpressure
        mon_restart();
        sent      = 0;
        guard     = 0;
        low_seen  = 1'b0;
        recovered = 1'b0;
        tx_data   = 8'h00;
        a_valid   = 1'b1;
        while (sent < 6 && guard < 1000) begin
            if (a_ready) begin
                if (low_seen) recovered = 1'b1;
                @(posedge clk);
                sent++;
            end else begin
                low_seen = 1'b1;
                @(posedge clk);
            end
            @(negedge clk);
            tx_data = 8'(sent);
            guard++;
        end
        a_valid = 1'b0;
        check_int("burst_accepted", sent, 6);
        check_bit("burst_ready_dropped", low_seen, 1'b1);
        check_bit("burst_ready_recovered", recovered, 1'b1);
        mon_wait(6, 600);
        mon_check_seq("burst", 8'h00, 6);
        @(negedge clk);
        check_bit("burst_busy_end", a_busy, 1'b0);

        // Full boundary: valid presented on the cycle the full FIFO is popped
        mon_restart();
        for (int i = 0; i < 5; i++) push_byte(0, 8'(8'h10 + i));
        check_bit("full_ready_low", a_ready, 1'b0);
        guard = 0;
        while (!a_done && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_bit("full_first_done", a_done, 1'b1);
        tx_data = 8'h15;
        a_valid = 1'b1;
        check_bit("full_ready_on_pop_cycle", a_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_bit("full_ready_after_pop", a_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        check_bit("full_ready_refilled", a_ready, 1'b0);
        mon_wait(6, 600);
        mon_check_seq("full", 8'h10, 6);

        // Reset during data bit 3 (frame cycles 17..20)
        mon_en = 1'b0;
        @(negedge clk);
        push_byte(0, 8'h00);
        repeat (18) @(negedge clk);
        check_bit("midrst_line_in_data", a_tx, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_bit("midrst_tx", a_tx, 1'b1);
        check_bit("midrst_busy", a_busy, 1'b0);
        check_bit("midrst_ready", a_ready, 1'b0);
        check_bit("midrst_done", a_done, 1'b0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        bad_done = 0;
        bad_line = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (a_done !== 1'b0) bad_done++;
            if (a_tx !== 1'b1) bad_line++;
        end
        check_int("midrst_no_done", bad_done, 0);
        check_int("midrst_line_idle", bad_line, 0);
        run_vec(v3c, "post_rst_3c");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
